// File: rtl/bc_pkg.sv
// bc_pkg: shared state encoding and digit constants for the guess round controller
package bc_pkg;
  typedef enum logic [2:0] {ENTRY, CHECK, WAIT, SHOW, WIN, LOSE} state_e;
  localparam logic [3:0] EMPTY_DIGIT = 4'hF;
  localparam logic [3:0] DIGIT_MAX = 4'd9;
endpackage

// File: rtl/guess_round_ctrl_if.sv
// guess_round_ctrl_if: keypad/scorer/display signals of the round sequencer
interface guess_round_ctrl_if;
  logic        digit_valid;
  logic [3:0]  digit;
  logic        clear;
  logic        new_game;
  logic [3:0]  strike;
  logic [3:0]  ball;
  logic [15:0] guess;
  logic [2:0]  slots_filled;
  logic        check_en;
  logic        result_valid;
  logic [3:0]  last_strike;
  logic [3:0]  last_ball;
  logic [3:0]  attempts;
  logic        digit_err;
  logic        win;
  logic        lose;
  modport master (
    output digit_valid, digit, clear, new_game, strike, ball,
    input  guess, slots_filled, check_en, result_valid, last_strike, last_ball,
           attempts, digit_err, win, lose
  );
  modport slave (
    input  digit_valid, digit, clear, new_game, strike, ball,
    output guess, slots_filled, check_en, result_valid, last_strike, last_ball,
           attempts, digit_err, win, lose
  );
endinterface

// File: rtl/bc_dup_check.sv
// bc_dup_check: rejects a digit that is out of range or already in a filled slot
module bc_dup_check
  import bc_pkg::*;
(
  input  logic [3:0]  digit,
  input  logic [15:0] guess,
  input  logic [2:0]  slots_filled,
  output logic        reject
);
  logic dup;
  // compare the digit against every slot that is already filled
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < 4; i++)
      dup = dup | ((3'(i) < slots_filled) && (guess[15-4*i -: 4] == digit));
  end
  assign reject = dup | (digit > DIGIT_MAX);
endmodule

// File: rtl/guess_round_ctrl.sv
// guess_round_ctrl: collects a 4-digit guess, strobes the scorer, latches its result and decides win/lose
module guess_round_ctrl
  import bc_pkg::*;
#(
  parameter int MAX_ATTEMPTS = 10,
  parameter int RESULT_LAT   = 1,
  parameter int SHOW_CYCLES  = 25_000_000
) (
  input logic clk,
  input logic rst,
  guess_round_ctrl_if.slave bus
);
  localparam int TMAX = SHOW_CYCLES > RESULT_LAT ? SHOW_CYCLES : RESULT_LAT;
  localparam int TW = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] LAT_END = TW'(RESULT_LAT - 1);
  localparam logic [TW-1:0] SHOW_END = TW'(SHOW_CYCLES - 1);
  localparam logic [3:0] ATT_MAX = 4'(MAX_ATTEMPTS);
  localparam logic [15:0] NO_GUESS = {4{EMPTY_DIGIT}};

  state_e state_q, state_d;
  logic [15:0] guess_q, guess_d;
  logic [2:0] slots_filled_q, slots_filled_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0] attempts_q, attempts_d, attempts_inc;
  logic [3:0] last_strike_q, last_strike_d, last_ball_q, last_ball_d;
  logic check_en_q, check_en_d, result_valid_q, result_valid_d;
  logic digit_err_q, digit_err_d, win_q, win_d, lose_q, lose_d;
  logic reject, sample;

  bc_dup_check u_dup (
    .digit        (bus.digit),
    .guess        (guess_q),
    .slots_filled (slots_filled_q),
    .reject       (reject)
  );

  // next state, slot register, attempt counter and registered output pulses
  always_comb begin
    state_d = state_q;
    guess_d = guess_q;
    slots_filled_d = slots_filled_q;
    attempts_d = attempts_q;
    last_strike_d = last_strike_q;
    last_ball_d = last_ball_q;
    digit_err_d = 1'b0;
    attempts_inc = attempts_q == 4'hF ? 4'hF : attempts_q + 4'd1;
    sample = state_q == WAIT && timer_q == LAT_END && !bus.new_game;
    if (bus.new_game) begin
      state_d = ENTRY;
      guess_d = NO_GUESS;
      slots_filled_d = 3'd0;
      attempts_d = 4'd0;
      last_strike_d = 4'd0;
      last_ball_d = 4'd0;
    end else begin
      case (state_q)
        ENTRY:
          if (bus.clear) begin
            guess_d = NO_GUESS;
            slots_filled_d = 3'd0;
          end else if (bus.digit_valid) begin
            if (reject) digit_err_d = 1'b1;
            else begin
              guess_d = (guess_q & ~(16'hF000 >> {slots_filled_q, 2'b00}))
                      | ({bus.digit, 12'h000} >> {slots_filled_q, 2'b00});
              slots_filled_d = slots_filled_q + 3'd1;
              state_d = slots_filled_q == 3'd3 ? CHECK : ENTRY;
            end
          end
        CHECK: state_d = WAIT;
        WAIT:
          if (sample) begin
            last_strike_d = bus.strike;
            last_ball_d = bus.ball;
            attempts_d = attempts_inc;
            state_d = bus.strike == 4'd4 ? WIN : attempts_inc == ATT_MAX ? LOSE : SHOW;
          end
        SHOW:
          if (timer_q == SHOW_END) begin
            state_d = ENTRY;
            guess_d = NO_GUESS;
            slots_filled_d = 3'd0;
          end
        default: ;
      endcase
    end
    timer_d = state_d != state_q ? '0 : timer_q + 1'b1;
    check_en_d = state_d == CHECK;
    result_valid_d = sample;
    win_d = state_d == WIN;
    lose_d = state_d == LOSE;
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ENTRY;
      guess_q <= NO_GUESS;
      slots_filled_q <= 3'd0;
      timer_q <= '0;
      attempts_q <= 4'd0;
      last_strike_q <= 4'd0;
      last_ball_q <= 4'd0;
      check_en_q <= 1'b0;
      result_valid_q <= 1'b0;
      digit_err_q <= 1'b0;
      win_q <= 1'b0;
      lose_q <= 1'b0;
    end else begin
      state_q <= state_d;
      guess_q <= guess_d;
      slots_filled_q <= slots_filled_d;
      timer_q <= timer_d;
      attempts_q <= attempts_d;
      last_strike_q <= last_strike_d;
      last_ball_q <= last_ball_d;
      check_en_q <= check_en_d;
      result_valid_q <= result_valid_d;
      digit_err_q <= digit_err_d;
      win_q <= win_d;
      lose_q <= lose_d;
    end
  end

  assign bus.guess = guess_q;
  assign bus.slots_filled = slots_filled_q;
  assign bus.check_en = check_en_q;
  assign bus.result_valid = result_valid_q;
  assign bus.last_strike = last_strike_q;
  assign bus.last_ball = last_ball_q;
  assign bus.attempts = attempts_q;
  assign bus.digit_err = digit_err_q;
  assign bus.win = win_q;
  assign bus.lose = lose_q;
endmodule

// File: tb/tb_guess_round_ctrl.sv
// tb_guess_round_ctrl: directed and randomized checks of the round sequencer against a game-level model
module tb_guess_round_ctrl;
  localparam int MA = 3;
  localparam int RL = 2;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  int q[$];
  int m_att, m_ls, m_lb;
  bit m_win, m_lose;
  int secret[4];

  guess_round_ctrl_if bus();

  guess_round_ctrl #(.MAX_ATTEMPTS(MA), .RESULT_LAT(RL), .SHOW_CYCLES(SC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mguess();
    logic [15:0] g = 16'hFFFF;
    for (int i = 0; i < q.size(); i++) g[15-4*i -: 4] = 4'(q[i]);
    return g;
  endfunction

  function automatic bit inq(input int d);
    foreach (q[i]) if (q[i] == d) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear_game();
    q.delete();
    m_att = 0;
    m_ls = 0;
    m_lb = 0;
    m_win = 0;
    m_lose = 0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".guess"}, bus.guess, mguess());
    chk({tag, ".slots"}, 16'(bus.slots_filled), 16'(q.size()));
    chk({tag, ".attempts"}, 16'(bus.attempts), 16'(m_att));
    chk({tag, ".last_strike"}, 16'(bus.last_strike), 16'(m_ls));
    chk({tag, ".last_ball"}, 16'(bus.last_ball), 16'(m_lb));
    chk({tag, ".win"}, 16'(bus.win), 16'(m_win));
    chk({tag, ".lose"}, 16'(bus.lose), 16'(m_lose));
  endtask

  task automatic chk_pulses(input string tag, input bit e_chk, input bit e_rv, input bit e_err);
    chk({tag, ".check_en"}, 16'(bus.check_en), 16'(e_chk));
    chk({tag, ".result_valid"}, 16'(bus.result_valid), 16'(e_rv));
    chk({tag, ".digit_err"}, 16'(bus.digit_err), 16'(e_err));
  endtask

  task automatic new_secret();
    for (int i = 0; i < 4; i++) begin
      bit again;
      do begin
        secret[i] = $urandom_range(0, 9);
        again = 0;
        for (int j = 0; j < i; j++) if (secret[j] == secret[i]) again = 1;
      end while (again);
    end
  endtask

  // one keypad cycle in ENTRY (or ignored in WIN/LOSE)
  task automatic press(input logic [3:0] d, input bit dv, input bit clr);
    bit e_err = 0, e_chk = 0;
    bus.digit_valid = dv;
    bus.digit = d;
    bus.clear = clr;
    tick();
    bus.digit_valid = 1'b0;
    bus.clear = 1'b0;
    bus.digit = 4'($urandom_range(0, 15));
    if (!m_win && !m_lose) begin
      if (clr) q.delete();
      else if (dv) begin
        if (d > 9 || inq(int'(d))) e_err = 1;
        else begin
          q.push_back(int'(d));
          e_chk = q.size() == 4;
        end
      end
    end
    chk_pulses("press", e_chk, 0, e_err);
    chk_state("press");
  endtask

  task automatic new_game();
    bus.new_game = 1'b1;
    bus.digit_valid = 1'b1;
    bus.digit = 4'd1;
    tick();
    bus.new_game = 1'b0;
    bus.digit_valid = 1'b0;
    model_clear_game();
    chk_pulses("new_game", 0, 0, 0);
    chk_state("new_game");
  endtask

  // called right after the cycle in which check_en was seen
  task automatic do_round(input bit force_sc, input int fs, input int fb, input bit stop_in_show);
    int s = 0, b = 0;
    if (force_sc) begin
      s = fs;
      b = fb;
    end else
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          if (q[i] == secret[j]) begin
            if (i == j) s++;
            else b++;
          end
    bus.strike = 4'($urandom_range(0, 15));
    bus.ball = 4'($urandom_range(0, 15));
    for (int k = 1; k <= RL; k++) begin
      tick();
      chk_pulses("wait", 0, 0, 0);
      chk_state("wait");
    end
    bus.strike = 4'(s);
    bus.ball = 4'(b);
    tick();
    bus.strike = 4'($urandom_range(0, 15));
    bus.ball = 4'($urandom_range(0, 15));
    m_ls = s;
    m_lb = b;
    m_att = m_att == 15 ? 15 : m_att + 1;
    m_win = s == 4;
    m_lose = !m_win && m_att == MA;
    chk_pulses("result", 0, 1, 0);
    chk_state("result");
    if (m_win || m_lose || stop_in_show) return;
    for (int k = 1; k < SC; k++) begin
      bus.digit_valid = k == 1;
      bus.digit = 4'($urandom_range(0, 15));
      tick();
      bus.digit_valid = 1'b0;
      chk_pulses("show", 0, 0, 0);
      chk_state("show");
    end
    tick();
    q.delete();
    chk_pulses("show_exit", 0, 0, 0);
    chk_state("show_exit");
  endtask

  task automatic enter_random();
    while (q.size() < 4) begin
      int r = $urandom_range(0, 99);
      if (r < 8) press(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1);
      else if (r < 20) press(4'($urandom_range(10, 15)), 1, 0);
      else if (r < 35 && q.size() > 0) press(4'(q[$urandom_range(0, q.size() - 1)]), 1, 0);
      else if (r < 42) press(4'($urandom_range(0, 15)), 0, 0);
      else press(4'($urandom_range(0, 9)), 1, 0);
    end
  endtask

  initial begin
    bus.digit_valid = 1'b0;
    bus.digit = 4'd0;
    bus.clear = 1'b0;
    bus.new_game = 1'b0;
    bus.strike = 4'd0;
    bus.ball = 4'd0;
    model_clear_game();
    repeat (2) @(posedge clk);
    #1;
    chk_pulses("reset", 0, 0, 0);
    chk_state("reset");
    @(negedge clk);
    rst = 1'b0;

    secret = '{1, 2, 3, 4};
    press(4'd1, 1, 0);
    press(4'd2, 1, 0);
    press(4'd3, 1, 0);
    press(4'd4, 1, 0);
    chk("win_guess_1234", bus.guess, 16'h1234);
    do_round(0, 0, 0, 0);
    chk("win_level", 16'(bus.win), 16'd1);
    chk("win_attempts", 16'(bus.attempts), 16'd1);
    press(4'd7, 1, 0);
    new_game();

    press(4'd5, 1, 0);
    press(4'd5, 1, 0);
    chk("dup_guess_5FFF", bus.guess, 16'h5FFF);
    press(4'hA, 1, 0);
    press(4'd0, 0, 1);

    press(4'd1, 1, 0);
    press(4'd2, 1, 0);
    press(4'd3, 1, 1);
    press(4'd9, 1, 0);
    press(4'd8, 1, 0);
    press(4'd7, 1, 0);
    press(4'd6, 1, 0);
    chk("clear_guess_9876", bus.guess, 16'h9876);
    do_round(0, 0, 0, 0);
    new_game();

    for (int r = 0; r < MA; r++) begin
      press(4'd5, 1, 0);
      press(4'd6, 1, 0);
      press(4'd7, 1, 0);
      press(4'd8, 1, 0);
      do_round(1, 1, 2, 0);
    end
    chk("lose_level", 16'(bus.lose), 16'd1);
    chk("lose_attempts", 16'(bus.attempts), 16'd3);
    press(4'd2, 1, 0);
    new_game();

    for (int g = 0; g < 4; g++) begin
      int rnd = 0;
      new_secret();
      while (!m_win && !m_lose) begin
        enter_random();
        if (g == 0 && rnd == 0) do_round(1, 5, 0, 0);
        else if (g == 1 && rnd == 0) do_round(1, 3, 3, 0);
        else do_round(0, 0, 0, 0);
        rnd++;
      end
      press(4'($urandom_range(0, 15)), 1, 0);
      new_game();
    end

    enter_random();
    for (int k = 1; k <= RL; k++) begin
      tick();
      chk_pulses("ng_wait", 0, 0, 0);
    end
    bus.strike = 4'd4;
    bus.ball = 4'd0;
    bus.new_game = 1'b1;
    tick();
    bus.new_game = 1'b0;
    model_clear_game();
    chk_pulses("ng_in_wait", 0, 0, 0);
    chk_state("ng_in_wait");
    for (int k = 0; k < RL + 2; k++) begin
      tick();
      chk_pulses("ng_after", 0, 0, 0);
      chk_state("ng_after");
    end

    new_secret();
    enter_random();
    do_round(0, 0, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    model_clear_game();
    chk_pulses("async_rst", 0, 0, 0);
    chk_state("async_rst");
    @(negedge clk);
    rst = 1'b0;
    press(4'd7, 1, 0);
    chk("post_rst_digit", bus.guess, 16'h7FFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
